// File: rtl/start_stop_conditioner.sv
// Start/stop pushbutton conditioner: sync, debounce, press edge,
// run toggle and long-press clear request for the stopwatch.
module start_stop_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter bit BTN_ACTIVE_HIGH   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press_pulse,
    output logic clear_pulse,
    output logic run
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (LONG_PRESS_CYCLES > 1) ?
                        $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_db;
    logic                   r_stable;
    logic                   r_press;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [HW-1:0]          r_hold;
    logic [HW-1:0]          w_hold_nxt;
    logic                   r_run;
    logic                   w_run_nxt;
    logic                   r_clear;
    logic                   w_clear_nxt;
    logic                   w_norm;
    logic                   w_s;
    logic                   w_rise;

    // Normalise so that 1 always means pressed from here on
    assign w_norm = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;
    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = (w_s != r_stable) && (r_db == DB_LAST) && w_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '0;
            r_db     <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_norm};
            r_press <= w_rise;
            if (w_s == r_stable) begin
                r_db <= '0;
            end else if (r_db == DB_LAST) begin
                r_stable <= w_s;
                r_db     <= '0;
            end else begin
                r_db <= r_db + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_run   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_run   <= w_run_nxt;
            r_clear <= w_clear_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_run_nxt   = r_run;
        w_clear_nxt = 1'b0;
        unique case (r_state)
            IDLE: w_state_nxt = IDLE;
            HELD: begin
                if (!r_stable) begin
                    w_state_nxt = IDLE;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt = LONG;
                    w_clear_nxt = 1'b1;
                    w_run_nxt   = 1'b0;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            LONG: begin
                if (!r_stable) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // An accepted press implies the stable level was low, so it wins
        if (w_rise) begin
            w_state_nxt = HELD;
            w_hold_nxt  = '0;
            w_run_nxt   = ~r_run;
            w_clear_nxt = 1'b0;
        end
    end

    assign btn_stable  = r_stable;
    assign press_pulse = r_press;
    assign clear_pulse = r_clear;
    assign run         = r_run;

endmodule

// File: tb/tb_start_stop_conditioner.sv
// Directed bench for start_stop_conditioner with an event scoreboard
// for press/clear pulses on an active-high and an active-low instance.
module tb_start_stop_conditioner;

    typedef struct {
        int cyc;
        bit clr;
        bit run;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b1;
    logic a_st, a_pp, a_cp, a_run;
    logic b_st, b_pp, b_cp, b_run;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int e0 = 0;
    bit exp_run = 1'b0;
    ev_t qa[$];
    ev_t qb[$];

    start_stop_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(20),
        .BTN_ACTIVE_HIGH(1'b1)
    ) u_a (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_a),
        .btn_stable(a_st),
        .press_pulse(a_pp),
        .clear_pulse(a_cp),
        .run(a_run)
    );

    start_stop_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(20),
        .BTN_ACTIVE_HIGH(1'b0)
    ) u_b (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_b),
        .btn_stable(b_st),
        .press_pulse(b_pp),
        .clear_pulse(b_cp),
        .run(b_run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_a(input bit clr, input bit rv);
        ev_t e;
        chk("a_evt_pending", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("a_evt_cyc", cyc, e.cyc);
            chk("a_evt_kind", 32'(clr), 32'(e.clr));
            chk("a_evt_run", 32'(rv), 32'(e.run));
        end
    endtask

    task automatic pop_b(input bit clr, input bit rv);
        ev_t e;
        chk("b_evt_pending", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("b_evt_cyc", cyc, e.cyc);
            chk("b_evt_kind", 32'(clr), 32'(e.clr));
            chk("b_evt_run", 32'(rv), 32'(e.run));
        end
    endtask

    // Monitor: every pulse must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (rst) begin
            if (a_pp === 1'b1) pop_a(1'b0, a_run);
            if (a_cp === 1'b1) pop_a(1'b1, a_run);
            if (b_pp === 1'b1) pop_b(1'b0, b_run);
            if (b_cp === 1'b1) pop_b(1'b1, b_run);
        end
    end

    initial begin
        // Reset with a toggling button
        tick(1);
        chk("rst_a", {a_st, a_pp, a_cp, a_run}, 0);
        chk("rst_b", {b_st, b_pp, b_cp, b_run}, 0);
        for (int i = 0; i < 3; i++) begin
            btn_a = ~btn_a;
            tick(1);
            chk("rst_hold_a", {a_st, a_pp, a_cp, a_run}, 0);
        end
        btn_a = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("rst_release_a", {a_st, a_pp, a_cp, a_run}, 0);
        chk("rst_release_b", {b_st, b_pp, b_cp, b_run}, 0);
        tick(3);

        // Clean press
        e0 = cyc;
        btn_a = 1'b1;
        exp_run = ~exp_run;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        tick(5);
        chk("clean_pre_stable", a_st, 0);
        tick(1);
        chk("clean_stable", a_st, 1);
        chk("clean_run", a_run, 32'(exp_run));
        tick(1);
        chk("clean_pulse_once", a_pp, 0);
        tick(3);
        btn_a = 1'b0;
        tick(8);
        chk("clean_released", a_st, 0);
        chk("clean_run_kept", a_run, 32'(exp_run));

        // Second press stops
        e0 = cyc;
        btn_a = 1'b1;
        exp_run = ~exp_run;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        tick(8);
        chk("second_run", a_run, 32'(exp_run));
        btn_a = 1'b0;
        tick(8);

        // Bouncing press
        btn_a = 1'b1;
        tick(1);
        btn_a = 1'b0;
        tick(1);
        btn_a = 1'b1;
        tick(1);
        btn_a = 1'b0;
        tick(1);
        e0 = cyc;
        btn_a = 1'b1;
        exp_run = ~exp_run;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        tick(5);
        chk("bounce_pre_stable", a_st, 0);
        tick(1);
        chk("bounce_stable", a_st, 1);
        chk("bounce_run", a_run, 32'(exp_run));
        tick(4);
        btn_a = 1'b0;
        tick(8);

        // Short glitch is invisible
        btn_a = 1'b1;
        tick(3);
        btn_a = 1'b0;
        tick(10);
        chk("glitch_stable", a_st, 0);
        chk("glitch_run", a_run, 32'(exp_run));

        // Long press from run=1
        e0 = cyc;
        btn_a = 1'b1;
        exp_run = ~exp_run;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        exp_run = 1'b0;
        qa.push_back('{e0 + 26, 1'b1, exp_run});
        tick(7);
        chk("long_run_after_press", a_run, 0);
        tick(18);
        chk("long_pre_clear", a_cp, 0);
        tick(1);
        chk("long_clear", a_cp, 1);
        chk("long_run", a_run, 0);
        tick(14);
        btn_a = 1'b0;
        tick(10);
        chk("long_released", a_st, 0);
        chk("long_run_final", a_run, 0);

        // Reset during a held press
        e0 = cyc;
        btn_a = 1'b1;
        exp_run = ~exp_run;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        tick(8);
        chk("midrst_run_before", a_run, 1);
        chk("midrst_stable_before", a_st, 1);
        rst = 1'b0;
        tick(1);
        chk("midrst_outputs", {a_st, a_pp, a_cp, a_run}, 0);
        tick(1);
        rst = 1'b1;
        e0 = cyc;
        exp_run = 1'b1;
        qa.push_back('{e0 + 6, 1'b0, exp_run});
        tick(5);
        chk("midrst_pre_accept_run", a_run, 0);
        chk("midrst_pre_accept_st", a_st, 0);
        tick(1);
        chk("midrst_repress_pulse", a_pp, 1);
        chk("midrst_repress_run", a_run, 1);
        tick(4);
        btn_a = 1'b0;
        tick(10);

        // Active-low button instance
        e0 = cyc;
        btn_b = 1'b0;
        qb.push_back('{e0 + 6, 1'b0, 1'b1});
        tick(5);
        chk("low_pre_stable", b_st, 0);
        tick(1);
        chk("low_stable", b_st, 1);
        chk("low_pulse", b_pp, 1);
        chk("low_run", b_run, 1);
        tick(4);
        btn_b = 1'b1;
        tick(10);
        chk("low_released", b_st, 0);
        chk("low_run_kept", b_run, 1);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
